// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM arbiter: FSM state encoding and the
// id-width helper used to size requester indices.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    // Bits needed to index n requesters; never less than 1.
    function automatic int unsigned clog2(input int unsigned n);
        for (int unsigned w = 1; w < 32; w++) begin
            if ((32'd1 << w) >= n) return w;
        end
        return 32;
    endfunction

endpackage

// File: rtl/ram_arb_picker.sv
// Combinational winner selection for the RAM arbiter.
// Macro RAM_ARB_RR_EN: defined -> search starts at ptr and wraps (round robin);
//                      undefined -> lowest requesting index wins, no ptr port.
// Ports:
//   req       in   pending requests
//   ptr       in   search start index (RAM_ARB_RR_EN only)
//   winner_c  out  one-hot winner, all zero when no request
//   idx_c     out  winner index, zero when no request
module ram_arb_picker #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
`ifdef RAM_ARB_RR_EN
    input  logic [ID_W-1:0]    ptr,
`endif
    output logic [NUM_REQ-1:0] winner_c,
    output logic [ID_W-1:0]    idx_c
);

    logic            found;
    int unsigned     j;
    logic [ID_W-1:0] jj;

    // First requester found in search order wins.
    always_comb begin
        winner_c = '0;
        idx_c    = '0;
        found    = 1'b0;
        j        = 0;
        jj       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef RAM_ARB_RR_EN
            j = (32'(ptr) + k) % NUM_REQ;
`else
            j = k;
`endif
            jj = ID_W'(j);
            if (!found && req[jj]) begin
                found = 1'b1;
                idx_c = jj;
            end
        end
        winner_c[idx_c] = found;
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one synchronous RAM between NUM_REQ requesters. Each accepted
// command is a single-beat read or write; reads return data with a one-cycle
// rvalid strobe two cycles after the grant.
// Macro RAM_ARB_RR_EN: defined -> round-robin arbitration; undefined -> fixed
// priority (lowest index wins).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req, we, addr, wdata  per-requester command (addr/wdata packed, slice i = requester i)
//   gnt                   one-hot pulse during the cycle the command is on the RAM
//   rvalid, rdata         one-hot read-return strobe and shared read data
//   busy                  arbiter not idle
//   ram_Din, ram_addr, ram_writeEn, ram_read   RAM command, zero outside ISSUE
//   ram_Dout              RAM read data, valid the cycle after the read edge
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          busy,
    output logic [DATA_WIDTH-1:0]         ram_Din,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic                          ram_writeEn,
    output logic                          ram_read,
    input  logic [DATA_WIDTH-1:0]         ram_Dout
);

    localparam int unsigned ID_W = clog2(NUM_REQ);

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic                   we_q, we_d;
    logic [NUM_REQ-1:0]     gnt_d, rvalid_d;
    logic [DATA_WIDTH-1:0]  rdata_d, din_d;
    logic [ADDR_WIDTH-1:0]  raddr_d;
    logic                   wen_d, rd_d, busy_d;
    logic [NUM_REQ-1:0]     win_oh;
    logic [ID_W-1:0]        win_idx;

`ifdef RAM_ARB_RR_EN
    logic [ID_W-1:0]        ptr_q, ptr_d;
`endif

    ram_arb_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req      (req),
`ifdef RAM_ARB_RR_EN
        .ptr      (ptr_q),
`endif
        .winner_c (win_oh),
        .idx_c    (win_idx)
    );

    // Next state and next values of every registered output.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        we_d     = we_q;
        gnt_d    = '0;
        rvalid_d = '0;
        rdata_d  = rdata;
        din_d    = '0;
        raddr_d  = '0;
        wen_d    = 1'b0;
        rd_d     = 1'b0;
`ifdef RAM_ARB_RR_EN
        ptr_d    = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_ISSUE;
                    id_d    = win_idx;
                    we_d    = we[win_idx];
                    gnt_d   = win_oh;
                    raddr_d = addr[32'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    din_d   = wdata[32'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                    wen_d   = we[win_idx];
                    rd_d    = ~we[win_idx];
`ifdef RAM_ARB_RR_EN
                    ptr_d   = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
`endif
                end
            end
            S_ISSUE: begin
                state_d = we_q ? S_IDLE : S_RESP;
            end
            S_RESP: begin
                rdata_d        = ram_Dout;
                rvalid_d[id_q] = 1'b1;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, command and output registers; reset drops the RAM strobes at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            id_q        <= '0;
            we_q        <= 1'b0;
            gnt         <= '0;
            rvalid      <= '0;
            rdata       <= '0;
            busy        <= 1'b0;
            ram_Din     <= '0;
            ram_addr    <= '0;
            ram_writeEn <= 1'b0;
            ram_read    <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            we_q        <= we_d;
            gnt         <= gnt_d;
            rvalid      <= rvalid_d;
            rdata       <= rdata_d;
            busy        <= busy_d;
            ram_Din     <= din_d;
            ram_addr    <= raddr_d;
            ram_writeEn <= wen_d;
            ram_read    <= rd_d;
        end
    end

`ifdef RAM_ARB_RR_EN
    // Round-robin search start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter with a behavioural synchronous RAM attached.
// A cycle-level reference model predicts each grant and read return; a
// monitor compares them against the DUT outputs.
module tb_ram_arbiter;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 2;
`ifdef RAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } cmd_t;
    typedef struct { int id; int cyc; } gexp_t;
    typedef struct { int id; logic [DW-1:0] data; int cyc; } rexp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NR-1:0]    req_v, we_v;
    logic [NR*AW-1:0] addr_v;
    logic [NR*DW-1:0] wdata_v;
    logic [NR-1:0]    gnt, rvalid;
    logic [DW-1:0]    rdata, ram_Din, ram_Dout;
    logic [AW-1:0]    ram_addr;
    logic             busy, ram_writeEn, ram_read;

    logic [DW-1:0] mem     [1<<AW];
    logic [DW-1:0] ref_mem [1<<AW];

    cmd_t  cq [NR][$];
    gexp_t gq [$];
    rexp_t rq [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int free_cyc = 0;
    int m_ptr = 0;
    int unsigned issue_pct = 100;
    bit pend_wr = 1'b0;
    int pend_cyc = 0;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_old;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk(clk), .rst_n(rst_n), .req(req_v), .we(we_v), .addr(addr_v), .wdata(wdata_v),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
        .ram_Din(ram_Din), .ram_addr(ram_addr), .ram_writeEn(ram_writeEn),
        .ram_read(ram_read), .ram_Dout(ram_Dout)
    );

    // Behavioural sync_ram: registered read port.
    always @(posedge clk) begin
        if (ram_writeEn) mem[ram_addr] <= ram_Din;
        if (ram_read)    ram_Dout      <= mem[ram_addr];
    end

    function automatic int pick(input logic [NR-1:0] r, input int p);
        for (int k = 0; k < NR; k++) begin
            int j;
            j = RR ? (p + k) % NR : k;
            if (r[j]) return j;
        end
        return 0;
    endfunction

    // Reference: arbiter free again 2 cycles after a write grant, 3 after a read.
    task automatic model_loop();
        int w;
        logic [AW-1:0] a;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                if (pend_wr && cyc == pend_cyc) ref_mem[pend_addr] = pend_old;
                pend_wr  = 1'b0;
                free_cyc = 0;
                m_ptr    = 0;
            end else begin
                cyc++;
                if (cyc >= free_cyc && req_v != '0) begin
                    w = pick(req_v, m_ptr);
                    a = addr_v[w*AW +: AW];
                    gq.push_back('{id: w, cyc: cyc});
                    if (we_v[w]) begin
                        pend_wr   = 1'b1;
                        pend_cyc  = cyc;
                        pend_addr = a;
                        pend_old  = ref_mem[a];
                        ref_mem[a] = wdata_v[w*DW +: DW];
                        free_cyc  = cyc + 2;
                    end else begin
                        pend_wr = 1'b0;
                        rq.push_back('{id: w, data: ref_mem[a], cyc: cyc + 2});
                        free_cyc = cyc + 3;
                    end
                    m_ptr = (w + 1) % NR;
                end
            end
        end
    endtask

    task automatic monitor_loop();
        gexp_t ge;
        rexp_t re;
        logic [NR-1:0] oh;
        forever begin
            @(negedge clk);
            if (gnt != '0) begin
                checks++;
                if (gq.size() == 0) begin
                    errors++;
                    $display("FAIL gnt_unexpected got=%b cyc=%0d", gnt, cyc);
                end else begin
                    ge = gq.pop_front();
                    oh = NR'(1) << ge.id;
                    if (gnt !== oh || cyc != ge.cyc) begin
                        errors++;
                        $display("FAIL gnt got=%b@%0d exp=%b@%0d", gnt, cyc, oh, ge.cyc);
                    end
                end
            end else if (gq.size() > 0 && cyc > gq[0].cyc) begin
                checks++; errors++;
                ge = gq.pop_front();
                $display("FAIL gnt_missing got=none exp_id=%0d@%0d", ge.id, ge.cyc);
            end
            if (rvalid != '0) begin
                checks++;
                if (rq.size() == 0) begin
                    errors++;
                    $display("FAIL rvalid_unexpected got=%b cyc=%0d", rvalid, cyc);
                end else begin
                    re = rq.pop_front();
                    oh = NR'(1) << re.id;
                    if (rvalid !== oh || rdata !== re.data || cyc != re.cyc) begin
                        errors++;
                        $display("FAIL rdata got=%b/%h@%0d exp=%b/%h@%0d",
                                 rvalid, rdata, cyc, oh, re.data, re.cyc);
                    end
                end
            end else if (rq.size() > 0 && cyc > rq[0].cyc) begin
                checks++; errors++;
                re = rq.pop_front();
                $display("FAIL rvalid_missing got=none exp_id=%0d@%0d", re.id, re.cyc);
            end
        end
    endtask

    // Requesters hold req until they see gnt, then may present the next command.
    task automatic drive_step();
        for (int i = 0; i < NR; i++) begin
            if (req_v[i] && gnt[i]) begin
                void'(cq[i].pop_front());
                req_v[i] = 1'b0;
            end
            if (!req_v[i] && cq[i].size() > 0 && $urandom_range(99, 0) < issue_pct) begin
                req_v[i] = 1'b1;
                we_v[i]  = cq[i][0].we;
                addr_v[i*AW +: AW] = cq[i][0].addr;
                wdata_v[i*DW +: DW] = cq[i][0].data;
            end
        end
    endtask

    task automatic run_cmds(input int budget, input string tag);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            drive_step();
            n++;
            done = (cq[0].size() == 0) && (cq[1].size() == 0) && (req_v == '0) &&
                   (gq.size() == 0) && (rq.size() == 0);
        end
        if (!done) begin
            errors++;
            $display("FAIL %s timeout got=busy exp=drained within %0d cycles", tag, budget);
        end
    endtask

    initial begin
        int n;
        logic [DW-1:0] r;
        req_v = '0; we_v = '0; addr_v = '0; wdata_v = '0;
        fork
            model_loop();
            monitor_loop();
        join_none

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || gnt !== '0 || rvalid !== '0 || ram_writeEn !== 1'b0 ||
                ram_read !== 1'b0 || rdata !== '0 || ram_addr !== '0 || ram_Din !== '0) begin
                errors++;
                $display("FAIL idle busy=%b gnt=%b we=%b rd=%b rdata=%h exp=all zero",
                         busy, gnt, ram_writeEn, ram_read, rdata);
            end
        end

        // Write then read back on requester 0.
        cq[0].push_back('{we: 1'b1, addr: AW'(5), data: DW'(11)});
        cq[0].push_back('{we: 1'b0, addr: AW'(5), data: DW'(0)});
        run_cmds(50, "wr_rd_5");
        repeat (3) @(negedge clk);
        checks++;
        if (rdata !== DW'(11)) begin
            errors++;
            $display("FAIL rdata_hold got=%h exp=%h", rdata, DW'(11));
        end

        // Fill the whole RAM via requester 1, read everything via requester 0.
        for (int i = 0; i < (1 << AW); i++)
            cq[1].push_back('{we: 1'b1, addr: AW'(i), data: DW'(2*i + 1)});
        run_cmds(5000, "fill");
        for (int i = 0; i < (1 << AW); i++)
            cq[0].push_back('{we: 1'b0, addr: AW'(i), data: DW'(0)});
        run_cmds(5000, "readback");

        // Both requesters held continuously, reading.
        issue_pct = 100;
        for (int k = 0; k < 4; k++) begin
            cq[0].push_back('{we: 1'b0, addr: AW'(10 + k), data: DW'(0)});
            cq[1].push_back('{we: 1'b0, addr: AW'(20 + k), data: DW'(0)});
        end
        run_cmds(100, "contend");

        // Read and write to the top address raised together.
        cq[0].push_back('{we: 1'b1, addr: AW'(1023), data: DW'(32'hABCD_0123)});
        cq[1].push_back('{we: 1'b0, addr: AW'(1023), data: DW'(0)});
        run_cmds(50, "top_addr");

        // Random mix on a small colliding address set.
        issue_pct = 60;
        for (int i = 0; i < NR; i++) begin
            for (int k = 0; k < 150; k++) begin
                int unsigned s;
                s = $urandom_range(7, 0);
                cq[i].push_back('{we: 1'($urandom_range(1, 0)),
                                  addr: (s < 4) ? AW'(s) : AW'(1016 + s),
                                  data: DW'($urandom)});
            end
        end
        run_cmds(3000, "random");

        // Reset during a write ISSUE abandons the write.
        @(negedge clk);
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0 +: AW] = AW'(7); wdata_v[0 +: DW] = DW'(99);
        n = 0;
        while (!gnt[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!gnt[0] || ram_writeEn !== 1'b1 || ram_addr !== AW'(7) || ram_Din !== DW'(99)) begin
            errors++;
            $display("FAIL rst_issue got gnt=%b we=%b addr=%0d din=%0d exp gnt0 we=1 addr=7 din=99",
                     gnt, ram_writeEn, ram_addr, ram_Din);
        end
        req_v[0] = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (ram_writeEn !== 1'b0 || ram_read !== 1'b0 || gnt !== '0 || busy !== 1'b0 || rvalid !== '0) begin
            errors++;
            $display("FAIL rst_drop got we=%b rd=%b gnt=%b busy=%b rvalid=%b exp=all zero",
                     ram_writeEn, ram_read, gnt, busy, rvalid);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || gnt !== '0 || rvalid !== '0) begin
                errors++;
                $display("FAIL post_rst got busy=%b gnt=%b rvalid=%b exp=0", busy, gnt, rvalid);
            end
        end
        cq[0].push_back('{we: 1'b0, addr: AW'(7), data: DW'(0)});
        run_cmds(50, "rd_7");
        r = rdata;
        checks++;
        if (r !== DW'(15)) begin
            errors++;
            $display("FAIL abandoned_write got=%0d exp=%0d", r, 15);
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
